// File: rtl/multi_cond_sequencer.sv
// multi_cond_sequencer
// Tracks N_COND condition inputs as sticky flags, remembers which one arrived
// first, and once armed waits for every condition to be seen. The wait can
// require ascending-index arrival order and is bounded by a cycle timeout.
// The 3-bit status code is the registered state; the status flags are
// registered from the next-state value so they line up with the code.

module multi_cond_sequencer #(
  parameter int N_COND  = 4,
  parameter int TIMEOUT = 200,
  parameter int ORDERED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_COND-1:0] cond,
  input  logic              arm,
  input  logic              clear,
  output logic [N_COND-1:0] seen,
  output logic [2:0]        first_idx,
  output logic              first_vld,
  output logic [2:0]        code,
  output logic              busy,
  output logic              done_pulse,
  output logic              done,
  output logic              fault
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ALL  = 3'd2,
    ST_DONE = 3'd3,
    ST_TOUT = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic        ORD_EN   = (ORDERED != 0);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [N_COND-1:0] seen_r;
  logic [2:0]        first_idx_r;
  logic              first_vld_r;
  logic [15:0]       cnt_r;
  logic [15:0]       cnt_nxt_s;
  logic              busy_r;
  logic              done_pulse_r;
  logic              done_r;
  logic              fault_r;

  logic [2:0]        low_idx_s;
  logic [N_COND-1:0] new_s;
  logic [N_COND-1:0] union_s;
  logic [N_COND-1:0] seen_inc_s;
  logic              contig_err_s;
  logic              order_err_s;

  assign new_s        = cond & ~seen_r;
  assign union_s      = seen_r | cond;
  assign seen_inc_s   = seen_r + {{(N_COND-1){1'b0}}, 1'b1};
  // A set seen vector is contiguous from bit 0 exactly when adding one clears it.
  assign contig_err_s = ((seen_r & seen_inc_s) != {N_COND{1'b0}});

  // Lowest set index of cond; scanning downwards lets the lowest index win ties.
  always_comb begin : lowest_index
    low_idx_s = 3'd0;
    for (int k = N_COND - 1; k >= 0; k--) begin
      low_idx_s = cond[k] ? 3'(k) : low_idx_s;
    end
  end

  // Order violation: a newly arriving bit with some lower bit still unseen.
  always_comb begin : order_check
    logic gap;
    order_err_s = 1'b0;
    gap         = 1'b0;
    for (int k = 1; k < N_COND; k++) begin
      gap = 1'b0;
      for (int j = 0; j < k; j++) begin
        gap = gap | ~union_s[j];
      end
      order_err_s = order_err_s | (new_s[k] & gap);
    end
  end

  // Next-state and wait-counter selection from the registered seen flags.
  always_comb begin : next_state
    state_nxt_s = ST_IDLE;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (arm && (seen_r != {N_COND{1'b0}})) begin
          cnt_nxt_s = 16'd0;
          if (ORD_EN && contig_err_s) begin
            state_nxt_s = ST_ERR;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (&seen_r) begin
          state_nxt_s = ST_ALL;
        end else if (ORD_EN && order_err_s) begin
          state_nxt_s = ST_ERR;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_TOUT;
        end else begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = cnt_r + 16'd1;
        end
      end
      ST_ALL:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_DONE;
      ST_TOUT: state_nxt_s = ST_TOUT;
      ST_ERR:  state_nxt_s = ST_ERR;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, sticky flags, first-arrival capture and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      seen_r       <= {N_COND{1'b0}};
      first_idx_r  <= 3'd0;
      first_vld_r  <= 1'b0;
      cnt_r        <= 16'd0;
      busy_r       <= 1'b0;
      done_pulse_r <= 1'b0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else if (clear) begin
      state_r      <= ST_IDLE;
      seen_r       <= {N_COND{1'b0}};
      first_idx_r  <= 3'd0;
      first_vld_r  <= 1'b0;
      cnt_r        <= 16'd0;
      busy_r       <= 1'b0;
      done_pulse_r <= 1'b0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      seen_r  <= seen_r | cond;
      cnt_r   <= cnt_nxt_s;
      if (!first_vld_r && (cond != {N_COND{1'b0}})) begin
        first_idx_r <= low_idx_s;
        first_vld_r <= 1'b1;
      end else begin
        first_idx_r <= first_idx_r;
        first_vld_r <= first_vld_r;
      end
      busy_r       <= (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_ALL);
      done_pulse_r <= (state_nxt_s == ST_ALL);
      done_r       <= (state_nxt_s == ST_DONE);
      fault_r      <= (state_nxt_s == ST_TOUT) || (state_nxt_s == ST_ERR);
    end
  end

  assign seen       = seen_r;
  assign first_idx  = first_idx_r;
  assign first_vld  = first_vld_r;
  assign code       = state_r;
  assign busy       = busy_r;
  assign done_pulse = done_pulse_r;
  assign done       = done_r;
  assign fault      = fault_r;

endmodule

// File: tb/tb_multi_cond_sequencer.sv
// Scoreboard bench for multi_cond_sequencer with three configurations:
//   A: N_COND=4 TIMEOUT=10 any order
//   B: N_COND=4 TIMEOUT=10 ordered
//   C: N_COND=8 TIMEOUT=1  any order
// Stimulus pushes hand-computed expectations; a negedge monitor pops them.

module tb_multi_cond_sequencer;

  logic clk;
  logic rst_n;

  logic [3:0] cond_a, cond_b;
  logic [7:0] cond_c;
  logic       arm_a, arm_b, arm_c;
  logic       clear_a, clear_b, clear_c;

  logic [3:0] seen_a, seen_b;
  logic [7:0] seen_c;
  logic [2:0] fidx_a, fidx_b, fidx_c;
  logic       fvld_a, fvld_b, fvld_c;
  logic [2:0] code_a, code_b, code_c;
  logic       busy_a, busy_b, busy_c;
  logic       dp_a, dp_b, dp_c;
  logic       done_a, done_b, done_c;
  logic       fault_a, fault_b, fault_c;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         inst;
    string      nm;
    logic [2:0] code;
    logic [7:0] seen;
    logic [2:0] fidx;
    logic       fvld;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];

  multi_cond_sequencer #(.N_COND(4), .TIMEOUT(10), .ORDERED(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .cond(cond_a), .arm(arm_a), .clear(clear_a),
    .seen(seen_a), .first_idx(fidx_a), .first_vld(fvld_a), .code(code_a),
    .busy(busy_a), .done_pulse(dp_a), .done(done_a), .fault(fault_a));

  multi_cond_sequencer #(.N_COND(4), .TIMEOUT(10), .ORDERED(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cond(cond_b), .arm(arm_b), .clear(clear_b),
    .seen(seen_b), .first_idx(fidx_b), .first_vld(fvld_b), .code(code_b),
    .busy(busy_b), .done_pulse(dp_b), .done(done_b), .fault(fault_b));

  multi_cond_sequencer #(.N_COND(8), .TIMEOUT(1), .ORDERED(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .cond(cond_c), .arm(arm_c), .clear(clear_c),
    .seen(seen_c), .first_idx(fidx_c), .first_vld(fvld_c), .code(code_c),
    .busy(busy_c), .done_pulse(dp_c), .done(done_c), .fault(fault_c));

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int inst, input string nm, input logic [2:0] c,
                            input logic [7:0] s, input logic [2:0] fi,
                            input logic fv, input logic dp);
    exp_t e;
    e.inst = inst; e.nm = nm; e.code = c; e.seen = s;
    e.fidx = fi; e.fvld = fv; e.dp = dp;
    exp_q.push_back(e);
  endtask

  task automatic check_direct(input string nm, input logic [2:0] got_code,
                              input logic got_fault, input logic [2:0] exp_code,
                              input logic exp_fault);
    checks++;
    if ((got_code !== exp_code) || (got_fault !== exp_fault)) begin
      failures++;
      $display("FAIL %s actual code=%b fault=%b required code=%b fault=%b",
               nm, got_code, got_fault, exp_code, exp_fault);
    end
  endtask

  // Monitor: pops every pending expectation and compares against the DUT.
  always @(negedge clk) begin
    exp_t       e;
    logic [18:0] act;
    logic [18:0] req;
    logic        eb, ed, ef;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      eb = (e.code == 3'd1) || (e.code == 3'd2);
      ed = (e.code == 3'd3);
      ef = (e.code == 3'd4) || (e.code == 3'd5);
      req = {e.code, eb, e.dp, ed, ef, e.seen, e.fidx, e.fvld};
      case (e.inst)
        0:       act = {code_a, busy_a, dp_a, done_a, fault_a, {4'b0000, seen_a}, fidx_a, fvld_a};
        1:       act = {code_b, busy_b, dp_b, done_b, fault_b, {4'b0000, seen_b}, fidx_b, fvld_b};
        default: act = {code_c, busy_c, dp_c, done_c, fault_c, seen_c, fidx_c, fvld_c};
      endcase
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL %s inst=%0d actual{code,busy,dp,done,fault,seen,fidx,fvld}=%b required=%b",
                 e.nm, e.inst, act, req);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cond_a = 4'h0; cond_b = 4'h0; cond_c = 8'h00;
    arm_a = 1'b0; arm_b = 1'b0; arm_c = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
    step();
    step();
    expect_out(0, "reset_a", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    expect_out(1, "reset_b", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    expect_out(2, "reset_c", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    check_direct("reset_direct_a", code_a, fault_a, 3'd0, 1'b0);
    check_direct("reset_direct_b", code_b, fault_b, 3'd0, 1'b0);
    check_direct("reset_direct_c", code_c, fault_c, 3'd0, 1'b0);
    step();
    rst_n = 1'b1;

    // ---- 1: basic any-order completion ----
    cond_a = 4'b0010;
    step(); expect_out(0, "t1_first", 3'd0, 8'h02, 3'd1, 1'b1, 1'b0);
    cond_a = 4'b0000; arm_a = 1'b1;
    step(); expect_out(0, "t1_arm", 3'd1, 8'h02, 3'd1, 1'b1, 1'b0);
    arm_a = 1'b0; cond_a = 4'b1101;
    step(); expect_out(0, "t1_rest", 3'd1, 8'h0F, 3'd1, 1'b1, 1'b0);
    cond_a = 4'b0000;
    step(); expect_out(0, "t1_all", 3'd2, 8'h0F, 3'd1, 1'b1, 1'b1);
    step(); expect_out(0, "t1_done", 3'd3, 8'h0F, 3'd1, 1'b1, 1'b0);
    arm_a = 1'b1;
    step(); expect_out(0, "t1_done_hold", 3'd3, 8'h0F, 3'd1, 1'b1, 1'b0);
    arm_a = 1'b0;

    // ---- 4: clear from DONE, then arm with nothing seen ----
    clear_a = 1'b1; cond_a = 4'b0100;
    step(); expect_out(0, "t4_clr_done", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    clear_a = 1'b0; cond_a = 4'b0000; arm_a = 1'b1;
    step(); expect_out(0, "t4_arm_empty", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    arm_a = 1'b0;

    // ---- 2: simultaneous arrival, then timeout ----
    cond_a = 4'b0110;
    step(); expect_out(0, "t2_simul", 3'd0, 8'h06, 3'd1, 1'b1, 1'b0);
    cond_a = 4'b0000; arm_a = 1'b1;
    step(); expect_out(0, "t2_wait0", 3'd1, 8'h06, 3'd1, 1'b1, 1'b0);
    arm_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(); expect_out(0, "t2_wait", 3'd1, 8'h06, 3'd1, 1'b1, 1'b0);
    end
    step(); expect_out(0, "t2_tout", 3'd4, 8'h06, 3'd1, 1'b1, 1'b0);
    check_direct("t2_tout_direct", code_a, fault_a, 3'd4, 1'b1);
    step(); expect_out(0, "t2_tout_hold", 3'd4, 8'h06, 3'd1, 1'b1, 1'b0);
    clear_a = 1'b1;
    step(); expect_out(0, "t4_clr_tout", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    clear_a = 1'b0;

    // ---- 4: clear while in WAIT ----
    cond_a = 4'b0011;
    step(); expect_out(0, "t4_pre", 3'd0, 8'h03, 3'd0, 1'b1, 1'b0);
    cond_a = 4'b0000; arm_a = 1'b1;
    step(); expect_out(0, "t4_wait", 3'd1, 8'h03, 3'd0, 1'b1, 1'b0);
    arm_a = 1'b0; clear_a = 1'b1;
    step(); expect_out(0, "t4_clr_wait", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    clear_a = 1'b0;

    // ---- 5: all-seen wins over timeout at cnt=TIMEOUT-1 ----
    cond_a = 4'b0001;
    step();
    cond_a = 4'b0000; arm_a = 1'b1;
    step(); expect_out(0, "t5_wait0", 3'd1, 8'h01, 3'd0, 1'b1, 1'b0);
    arm_a = 1'b0;
    for (int i = 0; i < 8; i++) step();
    expect_out(0, "t5_wait8", 3'd1, 8'h01, 3'd0, 1'b1, 1'b0);
    cond_a = 4'b1110;
    step(); expect_out(0, "t5_last", 3'd1, 8'h0F, 3'd0, 1'b1, 1'b0);
    cond_a = 4'b0000;
    step(); expect_out(0, "t5_all_not_tout", 3'd2, 8'h0F, 3'd0, 1'b1, 1'b1);
    step(); expect_out(0, "t5_done", 3'd3, 8'h0F, 3'd0, 1'b1, 1'b0);
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;

    // ---- 5: asynchronous reset mid-WAIT ----
    cond_a = 4'b0101;
    step();
    cond_a = 4'b0000; arm_a = 1'b1;
    step(); expect_out(0, "t5_pre_rst", 3'd1, 8'h05, 3'd0, 1'b1, 1'b0);
    arm_a = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    expect_out(0, "t5_async_rst", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    // ---- 3: ordered, out-of-order arrival -> ERR ----
    cond_b = 4'b0001;
    step(); expect_out(1, "t3_first", 3'd0, 8'h01, 3'd0, 1'b1, 1'b0);
    cond_b = 4'b0000; arm_b = 1'b1;
    step(); expect_out(1, "t3_arm", 3'd1, 8'h01, 3'd0, 1'b1, 1'b0);
    arm_b = 1'b0; cond_b = 4'b0100;
    step(); expect_out(1, "t3_err", 3'd5, 8'h05, 3'd0, 1'b1, 1'b0);
    cond_b = 4'b0000;
    step(); expect_out(1, "t3_err_hold", 3'd5, 8'h05, 3'd0, 1'b1, 1'b0);
    clear_b = 1'b1;
    step(); expect_out(1, "t4_clr_err", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    clear_b = 1'b0;

    // ---- 3: ordered, in-order arrival -> DONE ----
    cond_b = 4'b0001;
    step();
    cond_b = 4'b0000; arm_b = 1'b1;
    step(); expect_out(1, "t3b_arm", 3'd1, 8'h01, 3'd0, 1'b1, 1'b0);
    arm_b = 1'b0; cond_b = 4'b0010;
    step(); expect_out(1, "t3b_b1", 3'd1, 8'h03, 3'd0, 1'b1, 1'b0);
    cond_b = 4'b0100;
    step(); expect_out(1, "t3b_b2", 3'd1, 8'h07, 3'd0, 1'b1, 1'b0);
    cond_b = 4'b1000;
    step(); expect_out(1, "t3b_b3", 3'd1, 8'h0F, 3'd0, 1'b1, 1'b0);
    cond_b = 4'b0000;
    step(); expect_out(1, "t3b_all", 3'd2, 8'h0F, 3'd0, 1'b1, 1'b1);
    step(); expect_out(1, "t3b_done", 3'd3, 8'h0F, 3'd0, 1'b1, 1'b0);
    clear_b = 1'b1;
    step();
    clear_b = 1'b0;

    // ---- 3: ordered, arm with non-contiguous seen -> ERR from IDLE ----
    cond_b = 4'b0010;
    step(); expect_out(1, "t3c_first", 3'd0, 8'h02, 3'd1, 1'b1, 1'b0);
    cond_b = 4'b0000; arm_b = 1'b1;
    step(); expect_out(1, "t3c_arm_err", 3'd5, 8'h02, 3'd1, 1'b1, 1'b0);
    arm_b = 1'b0;

    // ---- 6: N_COND=8, TIMEOUT=1 ----
    cond_c = 8'h80;
    step(); expect_out(2, "t6_first7", 3'd0, 8'h80, 3'd7, 1'b1, 1'b0);
    cond_c = 8'h00; arm_c = 1'b1;
    step(); expect_out(2, "t6_wait", 3'd1, 8'h80, 3'd7, 1'b1, 1'b0);
    arm_c = 1'b0;
    step(); expect_out(2, "t6_tout", 3'd4, 8'h80, 3'd7, 1'b1, 1'b0);
    check_direct("t6_tout_direct", code_c, fault_c, 3'd4, 1'b1);
    clear_c = 1'b1;
    step();
    clear_c = 1'b0; cond_c = 8'h24;
    step(); expect_out(2, "t6_simul", 3'd0, 8'h24, 3'd2, 1'b1, 1'b0);
    cond_c = 8'h00;

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
